// File: rtl/fetch_align_buffer_pkg.sv
// Shared types for the fetch/align boundary.
//   IF_Instr     : one fetch slot (halfword + halfword pc + branch info)
//   AL_Instr     : one reassembled instruction handed to decode
//   HW_Entry     : one halfword as held in the align FIFO
//   RVC_OPC_FULL : low opcode bits marking a 32-bit instruction
package fetch_align_buffer_pkg;

  localparam logic [1:0] RVC_OPC_FULL = 2'b11;

  typedef struct packed {
    logic [15:0] instr;
    logic [30:0] pc;
    logic        valid;
    logic [5:0]  branchID;
    logic        branchPred;
  } IF_Instr;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        compr;
    logic        illegal;
    logic [5:0]  branchID;
    logic        branchPred;
  } AL_Instr;

  typedef struct packed {
    logic [15:0] instr;
    logic [30:0] pc;
    logic [5:0]  branchID;
    logic        branchPred;
  } HW_Entry;

  function automatic HW_Entry to_entry(input IF_Instr s);
    HW_Entry e;
    e.instr      = s.instr;
    e.pc         = s.pc;
    e.branchID   = s.branchID;
    e.branchPred = s.branchPred;
    return e;
  endfunction

endpackage

// File: rtl/hw_compact.sv
// Combinational prefix-sum compactor.
//   i_slots : NUM_BLOCKS input slots
//   i_mask  : which slots to keep
//   o_list  : kept slots packed densely from index 0 in ascending slot
//             order; unused entries are all-zero (valid=0)
//   o_count : number of kept slots
module hw_compact
  import fetch_align_buffer_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS = 4
) (
  input  IF_Instr                           i_slots [NUM_BLOCKS],
  input  logic [NUM_BLOCKS-1:0]             i_mask,
  output IF_Instr                           o_list  [NUM_BLOCKS],
  output logic [$clog2(NUM_BLOCKS+1)-1:0]   o_count
);

  localparam int unsigned CW = $clog2(NUM_BLOCKS + 1);
  localparam int unsigned IW = $clog2(NUM_BLOCKS);

  always_comb begin
    o_list  = '{default: '0};
    o_count = '0;
    for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
      if (i_mask[IW'(i)]) begin
        o_list[IW'(o_count)]       = i_slots[IW'(i)];
        o_list[IW'(o_count)].valid = 1'b1;
        o_count                    = o_count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_align_buffer.sv
// Fetch align buffer: compacts valid fetch halfwords into a FIFO and
// reassembles up to NUM_UOPS RV32/RVC instructions per cycle for decode.
//   clk, rst    : clock, synchronous active-high reset
//   IN_clear    : flush; drops buffered and incoming halfwords
//   IN_instrs   : NUM_BLOCKS fetch slots
//   IN_stall    : decode cannot accept; output register holds
//   OUT_full    : fetch must hold its block (free < NUM_BLOCKS)
//   OUT_instrs  : registered group of assembled instructions
module fetch_align_buffer
  import fetch_align_buffer_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS = 4,
  parameter int unsigned NUM_UOPS   = 2,
  parameter int unsigned DEPTH      = 16
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    IN_clear,
  input  IF_Instr IN_instrs [NUM_BLOCKS],
  input  logic    IN_stall,
  output logic    OUT_full,
  output AL_Instr OUT_instrs [NUM_UOPS]
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned BW  = $clog2(NUM_BLOCKS + 1);
  localparam int unsigned BIW = $clog2(NUM_BLOCKS);
  localparam int unsigned WIN = 2 * NUM_UOPS;
  localparam int unsigned WIW = $clog2(WIN);
  localparam int unsigned UIW = (NUM_UOPS > 1) ? $clog2(NUM_UOPS) : 1;

  HW_Entry       r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  AL_Instr       r_out [NUM_UOPS];

  logic [NUM_BLOCKS-1:0] w_mask;
  IF_Instr               w_list [NUM_BLOCKS];
  logic [BW-1:0]         w_push;
  HW_Entry               w_win  [WIN];
  logic [WIN-1:0]        w_win_v;
  AL_Instr               w_asm  [NUM_UOPS];
  logic [CW-1:0]         w_pop;
  int unsigned           w_pos;
  int unsigned           w_k;
  logic                  w_stop;
  HW_Entry               w_lo;
  HW_Entry               w_hi;

  assign OUT_full = r_count > CW'(DEPTH - NUM_BLOCKS);

  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
      w_mask[BIW'(i)] = IN_instrs[BIW'(i)].valid && !OUT_full && !IN_clear;
    end
  end

  hw_compact #(
    .NUM_BLOCKS(NUM_BLOCKS)
  ) u_compact (
    .i_slots (IN_instrs),
    .i_mask  (w_mask),
    .o_list  (w_list),
    .o_count (w_push)
  );

  // The assembly window is the buffered halfwords followed by this cycle's
  // compacted input, so a halfword can reach the output register on the
  // same edge it is written into the FIFO. Entries consumed from the input
  // part are still written; the head simply moves past them.
  always_comb begin
    w_win   = '{default: '0};
    w_win_v = '0;
    w_k     = 0;
    for (int unsigned j = 0; j < WIN; j++) begin
      if (j < 32'(r_count)) begin
        w_win[WIW'(j)]   = r_mem[r_head + PW'(j)];
        w_win_v[WIW'(j)] = 1'b1;
      end else begin
        w_k = j - 32'(r_count);
        if (w_k < NUM_BLOCKS) begin
          w_win[WIW'(j)]   = to_entry(w_list[BIW'(w_k)]);
          w_win_v[WIW'(j)] = w_list[BIW'(w_k)].valid;
        end
      end
    end
  end

  always_comb begin
    w_asm  = '{default: '0};
    w_pos  = 0;
    w_stop = 1'b0;
    w_lo   = '0;
    w_hi   = '0;
    for (int unsigned u = 0; u < NUM_UOPS; u++) begin
      if (!w_stop && w_pos < WIN && w_win_v[WIW'(w_pos)]) begin
        w_lo = w_win[WIW'(w_pos)];
        if (w_lo.instr[1:0] != RVC_OPC_FULL) begin
          w_asm[UIW'(u)] = '{valid: 1'b1, instr: {16'b0, w_lo.instr},
                             pc: {w_lo.pc, 1'b0}, compr: 1'b1, illegal: 1'b0,
                             branchID: w_lo.branchID, branchPred: w_lo.branchPred};
          w_pos = w_pos + 1;
        end else if (w_pos + 1 < WIN && w_win_v[WIW'(w_pos + 1)]) begin
          w_hi = w_win[WIW'(w_pos + 1)];
          if (w_hi.pc == w_lo.pc + 31'd1) begin
            w_asm[UIW'(u)] = '{valid: 1'b1, instr: {w_hi.instr, w_lo.instr},
                               pc: {w_lo.pc, 1'b0}, compr: 1'b0, illegal: 1'b0,
                               branchID: w_hi.branchID, branchPred: w_hi.branchPred};
            w_pos = w_pos + 2;
          end else begin
            // Non-sequential successor: the first half can never complete.
            w_asm[UIW'(u)] = '{valid: 1'b1, instr: {16'b0, w_lo.instr},
                               pc: {w_lo.pc, 1'b0}, compr: 1'b0, illegal: 1'b1,
                               branchID: w_lo.branchID, branchPred: w_lo.branchPred};
            w_pos = w_pos + 1;
          end
        end else begin
          // 32-bit instruction waiting for its second half.
          w_stop = 1'b1;
        end
      end else begin
        w_stop = 1'b1;
      end
    end
    w_pop = CW'(w_pos);
  end

  always_ff @(posedge clk) begin
    if (rst || IN_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_out   <= '{default: '0};
    end else begin
      for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
        if (w_list[BIW'(i)].valid) begin
          r_mem[r_tail + PW'(i)] <= to_entry(w_list[BIW'(i)]);
        end
      end
      r_tail <= r_tail + PW'(w_push);
      if (!IN_stall) begin
        r_out   <= w_asm;
        r_head  <= r_head + PW'(w_pop);
        r_count <= r_count + CW'(w_push) - w_pop;
      end else begin
        r_count <= r_count + CW'(w_push);
      end
    end
  end

  always_comb begin
    OUT_instrs = r_out;
  end

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Scoreboard bench for fetch_align_buffer: stimulus pushes hand-computed
// expected instructions (optionally with the cycle they must appear in);
// a monitor pops and compares whatever decode would sample (!IN_stall).
module tb_fetch_align_buffer;
  import fetch_align_buffer_pkg::*;

  localparam int unsigned NB = 4;
  localparam int unsigned NU = 2;
  localparam int unsigned DP = 16;

  logic    clk = 1'b0;
  logic    rst;
  logic    IN_clear;
  logic    IN_stall;
  logic    OUT_full;
  IF_Instr IN_instrs  [NB];
  AL_Instr OUT_instrs [NU];

  typedef struct {
    AL_Instr a;
    int      cyc;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   cur;

  AL_Instr A0;
  AL_Instr A1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fetch_align_buffer #(
    .NUM_BLOCKS(NB),
    .NUM_UOPS(NU),
    .DEPTH(DP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .IN_clear   (IN_clear),
    .IN_instrs  (IN_instrs),
    .IN_stall   (IN_stall),
    .OUT_full   (OUT_full),
    .OUT_instrs (OUT_instrs)
  );

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic AL_Instr al(input logic [31:0] pc, input logic [31:0] ins, input bit compr,
                                 input bit ill, input logic [5:0] bid, input bit bp);
    AL_Instr a;
    a.valid      = 1'b1;
    a.instr      = ins;
    a.pc         = pc;
    a.compr      = compr;
    a.illegal    = ill;
    a.branchID   = bid;
    a.branchPred = bp;
    return a;
  endfunction

  task automatic expect_al(input AL_Instr a, input int c);
    exp_t e;
    e.a   = a;
    e.cyc = c;
    q.push_back(e);
  endtask

  task automatic slot(input int s, input bit v, input logic [30:0] pc, input logic [15:0] ins,
                      input logic [5:0] bid, input bit bp);
    IN_instrs[s].instr      = ins;
    IN_instrs[s].pc         = pc;
    IN_instrs[s].valid      = v;
    IN_instrs[s].branchID   = bid;
    IN_instrs[s].branchPred = bp;
  endtask

  task automatic idle_blk();
    for (int i = 0; i < NB; i++) IN_instrs[i] = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(q.size() == 0, "drain", 64'(q.size()), 64'd0);
  endtask

  // Backpressure stream: halfword k at pc 0x3000+k, 16-bit opcode.
  task automatic put16(input int s, input int k);
    logic [15:0] ins;
    logic [5:0]  bid;
    ins = 16'h6001 + 16'(4 * k);
    bid = 6'(k);
    slot(s, 1'b1, 31'h3000 + 31'(k), ins, bid, bid[0]);
    expect_al(al(32'h6000 + 32'(2 * k), {16'h0, ins}, 1'b1, 1'b0, bid, bid[0]), -1);
  endtask

  task automatic hold_chk();
    chk(OUT_instrs[0] == A0, "stall_hold0", {OUT_instrs[0].pc, OUT_instrs[0].instr}, {A0.pc, A0.instr});
    chk(OUT_instrs[1] == A1, "stall_hold1", {OUT_instrs[1].pc, OUT_instrs[1].instr}, {A1.pc, A1.instr});
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && !IN_stall) begin
      for (int i = 0; i < NU; i++) begin
        if (OUT_instrs[i].valid) begin
          if (q.size() == 0) begin
            chk(1'b0, "unexpected_out", {OUT_instrs[i].pc, OUT_instrs[i].instr}, 64'd0);
          end else begin
            e = q.pop_front();
            chk(OUT_instrs[i] == e.a, "out_data",
                {OUT_instrs[i].pc, OUT_instrs[i].instr}, {e.a.pc, e.a.instr});
            if (e.cyc >= 0) chk(cyc == e.cyc, "out_cycle", 64'(cyc), 64'(e.cyc));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    IN_clear = 1'b0;
    IN_stall = 1'b0;
    idle_blk();
    A0 = al(32'h6000, 32'h6001, 1'b1, 1'b0, 6'd0, 1'b0);
    A1 = al(32'h6002, 32'h6005, 1'b1, 1'b0, 6'd1, 1'b1);

    // Reset state
    repeat (2) tick();
    chk(OUT_full == 1'b0, "reset_full", 64'(OUT_full), 64'd0);
    for (int i = 0; i < NU; i++)
      chk(OUT_instrs[i] == '0, "reset_out", {OUT_instrs[i].pc, OUT_instrs[i].instr}, 64'd0);
    rst = 1'b0;
    tick();

    // 1. Four RVC halfwords at 0x1000
    for (int s = 0; s < 4; s++) slot(s, 1'b1, 31'h800 + 31'(s), 16'h1001 + 16'(s * 16), 6'(s), s[0]);
    cur = cyc;
    expect_al(al(32'h1000, 32'h1001, 1'b1, 1'b0, 6'd0, 1'b0), cur + 1);
    expect_al(al(32'h1002, 32'h1011, 1'b1, 1'b0, 6'd1, 1'b1), cur + 1);
    expect_al(al(32'h1004, 32'h1021, 1'b1, 1'b0, 6'd2, 1'b0), cur + 2);
    expect_al(al(32'h1006, 32'h1031, 1'b1, 1'b0, 6'd3, 1'b1), cur + 2);
    tick();
    idle_blk();
    drain(10);

    // 2. 32-bit instruction split across blocks (low half slot 3 @0x200E)
    slot(3, 1'b1, 31'h1007, 16'h8493, 6'd5, 1'b0);
    cur = cyc;
    expect_al(al(32'h200E, 32'h12348493, 1'b0, 1'b0, 6'd9, 1'b1), cur + 2);
    expect_al(al(32'h2012, 32'h2001, 1'b1, 1'b0, 6'd10, 1'b0), cur + 2);
    expect_al(al(32'h2014, 32'h2005, 1'b1, 1'b0, 6'd11, 1'b0), cur + 3);
    expect_al(al(32'h2016, 32'h2009, 1'b1, 1'b0, 6'd12, 1'b0), cur + 3);
    tick();
    idle_blk();
    slot(0, 1'b1, 31'h1008, 16'h1234, 6'd9, 1'b1);
    for (int s = 1; s < 4; s++) slot(s, 1'b1, 31'h1008 + 31'(s), 16'h2001 + 16'(4 * (s - 1)), 6'(9 + s), 1'b0);
    tick();
    idle_blk();
    drain(10);

    // 3. Orphan first half at 0x300E, next block at 0x4000
    slot(3, 1'b1, 31'h1807, 16'hABC3, 6'd3, 1'b1);
    cur = cyc;
    expect_al(al(32'h300E, 32'h0000ABC3, 1'b0, 1'b1, 6'd3, 1'b1), cur + 2);
    expect_al(al(32'h4000, 32'h3001, 1'b1, 1'b0, 6'd20, 1'b0), cur + 2);
    expect_al(al(32'h4002, 32'h3005, 1'b1, 1'b0, 6'd21, 1'b0), cur + 3);
    expect_al(al(32'h4004, 32'h3009, 1'b1, 1'b0, 6'd22, 1'b0), cur + 3);
    expect_al(al(32'h4006, 32'h300D, 1'b1, 1'b0, 6'd23, 1'b0), cur + 4);
    tick();
    idle_blk();
    for (int s = 0; s < 4; s++) slot(s, 1'b1, 31'h2000 + 31'(s), 16'h3001 + 16'(4 * s), 6'(20 + s), 1'b0);
    tick();
    idle_blk();
    drain(10);

    // 6. Sparse mask 4'b1010 (invalid slots carry junk)
    slot(0, 1'b0, 31'h7777, 16'h0001, 6'd7, 1'b1);
    slot(1, 1'b1, 31'h0501, 16'h5001, 6'd1, 1'b0);
    slot(2, 1'b0, 31'h7778, 16'h0003, 6'd7, 1'b1);
    slot(3, 1'b1, 31'h0503, 16'h5005, 6'd3, 1'b1);
    cur = cyc;
    expect_al(al(32'h0A02, 32'h5001, 1'b1, 1'b0, 6'd1, 1'b0), cur + 1);
    expect_al(al(32'h0A06, 32'h5005, 1'b1, 1'b0, 6'd3, 1'b1), cur + 1);
    tick();
    idle_blk();
    drain(10);

    // 4. Backpressure: load A0/A1, then stall while filling to 13
    for (int s = 0; s < 4; s++) put16(s, s);
    tick();
    IN_stall = 1'b1;
    for (int s = 0; s < 4; s++) put16(s, 4 + s);
    hold_chk();
    chk(OUT_full == 1'b0, "full_at_2", 64'(OUT_full), 64'd0);
    tick();
    for (int s = 0; s < 4; s++) put16(s, 8 + s);
    hold_chk();
    tick();
    chk(OUT_full == 1'b0, "full_at_10", 64'(OUT_full), 64'd0);
    idle_blk();
    put16(0, 12);
    put16(1, 13);
    hold_chk();
    tick();
    chk(OUT_full == 1'b0, "full_at_12", 64'(OUT_full), 64'd0);
    idle_blk();
    put16(0, 14);
    hold_chk();
    tick();
    chk(OUT_full == 1'b1, "full_at_13", 64'(OUT_full), 64'd1);
    for (int s = 0; s < 4; s++) slot(s, 1'b1, 31'h7000 + 31'(s), 16'h7001, 6'd63, 1'b1);
    hold_chk();
    tick();
    chk(OUT_full == 1'b1, "full_drop", 64'(OUT_full), 64'd1);
    hold_chk();
    idle_blk();
    IN_stall = 1'b0;
    drain(40);

    // 5. Flush while the FIFO spans the pointer wrap (tail is mid-array here)
    IN_stall = 1'b1;
    for (int b = 0; b < 3; b++) begin
      for (int s = 0; s < 4; s++) slot(s, 1'b1, 31'h4000 + 31'(4 * b + s), 16'h4001, 6'd0, 1'b0);
      tick();
    end
    IN_stall = 1'b0;
    IN_clear = 1'b1;
    for (int s = 0; s < 4; s++) slot(s, 1'b1, 31'h4100 + 31'(s), 16'h4101, 6'd0, 1'b0);
    tick();
    IN_clear = 1'b0;
    idle_blk();
    chk(OUT_full == 1'b0, "flush_full", 64'(OUT_full), 64'd0);
    for (int i = 0; i < NU; i++)
      chk(OUT_instrs[i].valid == 1'b0, "flush_valid", 64'(OUT_instrs[i].valid), 64'd0);
    repeat (4) tick();
    slot(0, 1'b1, 31'h5000, 16'h9001, 6'd30, 1'b0);
    slot(1, 1'b1, 31'h5001, 16'h9005, 6'd31, 1'b1);
    cur = cyc;
    expect_al(al(32'hA000, 32'h9001, 1'b1, 1'b0, 6'd30, 1'b0), cur + 1);
    expect_al(al(32'hA002, 32'h9005, 1'b1, 1'b0, 6'd31, 1'b1), cur + 1);
    tick();
    idle_blk();
    drain(10);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
